digit_serial_alu: RTL

DIGIT_SERIAL_ALU -- requirements
Module: digit_serial_alu

---
 rtl/alu_pkg.sv | 30 +++
 rtl/digit_alu.sv | 46 ++++
 rtl/digit_serial_alu.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and parameter checks for the digit-serial ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    AND  = 3'd2,
    OR   = 3'd3,
    XOR  = 3'd4,
    SLT  = 3'd5,
    SLTU = 3'd6
  } AluOp;

  typedef enum logic [2:0] {
    INC     = 3'd0,
    BITS_8  = 3'd1,
    BITS_12 = 3'd2,
    BITS_16 = 3'd3,
    FULL    = 3'd4
  } OperandLen;

  // Legal digit widths are 1/2/4/8 and must tile the word exactly; the
  // word must be wide enough to hold the 16-bit operand field.
  function automatic bit width_ok(input int xlen, input int digit_w);
    bit legal_digit;
    legal_digit = (digit_w == 1) || (digit_w == 2) || (digit_w == 4) || (digit_w == 8);
    return legal_digit && (xlen >= 16) && ((xlen % digit_w) == 0);
  endfunction

endpackage

// File: rtl/digit_alu.sv
// One digit of the serial datapath: add/subtract or bitwise logic on a slice.
module digit_alu
  import alu_pkg::*;
#(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               carry_in,
  input  AluOp               op,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry,
  output logic               overflow
);

  logic               subtract;
  logic [DIGIT_W-1:0] b_eff;
  logic [DIGIT_W:0]   sum;

  // Digit sum with optional inversion of b for the subtracting ops.
  always_comb begin
    subtract = (op == SUB) || (op == SLT) || (op == SLTU);
    b_eff    = subtract ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, carry_in};
    overflow = (a[DIGIT_W-1] == b_eff[DIGIT_W-1]) && (sum[DIGIT_W-1] != a[DIGIT_W-1]);
    case (op)
      AND: begin
        digit = a & b;
        carry = 1'b0;
      end
      OR: begin
        digit = a | b;
        carry = 1'b0;
      end
      XOR: begin
        digit = a ^ b;
        carry = 1'b0;
      end
      default: begin
        digit = sum[DIGIT_W-1:0];
        carry = sum[DIGIT_W];
      end
    endcase
  end

endmodule

// File: rtl/digit_serial_alu.sv
// Digit-serial ALU: processes DIGIT_W bits per cycle, LSB digit first.
// INC always adds (op is ignored) and stops at the first digit without carry.
module digit_serial_alu
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DIGIT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  AluOp            op,
  input  OperandLen       len,
  input  logic            w2_signed,
  input  logic [XLEN-1:0] word1,
  input  logic [XLEN-1:0] word2,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] result,
  output logic            carry_out
);

  localparam int NDIG  = XLEN / DIGIT_W;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int SH_W  = $clog2(XLEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  if (!width_ok(XLEN, DIGIT_W)) begin : g_bad_width
    $error("digit_serial_alu: DIGIT_W must be 1/2/4/8 and divide XLEN (XLEN >= 16)");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t               state, state_next;
  logic [IDX_W-1:0]     idx;
  logic                 carry;
  AluOp                 op_q;
  logic                 inc_q;
  logic [XLEN-1:0]      w1_q, w2_q, w2_ext;
  AluOp                 slice_op;
  logic                 slice_cin, slice_carry, slice_ov, last_digit;
  logic [DIGIT_W-1:0]   slice_digit;
  logic [XLEN-1:0]      w1_next, rotated, final_result;
  logic [SH_W-1:0]      rot_amt;

  // Operand-2 extension selected by len and w2_signed.
  always_comb begin
    case (len)
      INC:     w2_ext = XLEN'(word2[DIGIT_W-1:0]);
      BITS_8:  w2_ext = w2_signed ? XLEN'($signed(word2[7:0]))  : XLEN'(word2[7:0]);
      BITS_12: w2_ext = w2_signed ? XLEN'($signed(word2[11:0])) : XLEN'(word2[11:0]);
      BITS_16: w2_ext = w2_signed ? XLEN'($signed(word2[15:0])) : XLEN'(word2[15:0]);
      default: w2_ext = word2;
    endcase
  end

  digit_alu #(.DIGIT_W(DIGIT_W)) u_digit (
    .a        (w1_q[DIGIT_W-1:0]),
    .b        (w2_q[DIGIT_W-1:0]),
    .carry_in (slice_cin),
    .op       (slice_op),
    .digit    (slice_digit),
    .carry    (slice_carry),
    .overflow (slice_ov)
  );

  // Digit control: carry injection, termination and final result assembly.
  always_comb begin
    slice_op  = inc_q ? ADD : op_q;
    if (idx == {IDX_W{1'b0}}) begin
      slice_cin = (slice_op == SUB) || (slice_op == SLT) || (slice_op == SLTU);
    end else begin
      slice_cin = carry;
    end
    // word1 rotates right with each new digit entering at the top; for an
    // early INC stop the processed digits are rotated back into place.
    w1_next    = {slice_digit, w1_q[XLEN-1:DIGIT_W]};
    rot_amt    = SH_W'(LAST_IDX - idx) * SH_W'(DIGIT_W);
    rotated    = XLEN'({w1_next, w1_next} >> rot_amt);
    last_digit = (idx == LAST_IDX) || (inc_q && !slice_carry);
    case (slice_op)
      SLT:     final_result = {{(XLEN-1){1'b0}}, slice_digit[DIGIT_W-1] ^ slice_ov};
      SLTU:    final_result = {{(XLEN-1){1'b0}}, ~slice_carry};
      default: final_result = rotated;
    endcase
  end

  // Next-state logic for the IDLE/RUN/DONE handshake FSM.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = req_valid ? RUN : IDLE;
      RUN:     state_next = last_digit ? DONE : RUN;
      DONE:    state_next = rsp_ready ? IDLE : DONE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Operand capture, digit shifting and result registration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= {IDX_W{1'b0}};
      carry     <= 1'b0;
      op_q      <= ADD;
      inc_q     <= 1'b0;
      w1_q      <= {XLEN{1'b0}};
      w2_q      <= {XLEN{1'b0}};
      result    <= {XLEN{1'b0}};
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q  <= op;
            inc_q <= (len == INC);
            w1_q  <= word1;
            w2_q  <= w2_ext;
            idx   <= {IDX_W{1'b0}};
            carry <= 1'b0;
          end
        end
        RUN: begin
          w1_q  <= w1_next;
          w2_q  <= w2_q >> DIGIT_W;
          carry <= slice_carry;
          idx   <= last_digit ? {IDX_W{1'b0}} : idx + IDX_W'(1);
          if (last_digit) begin
            result    <= final_result;
            carry_out <= slice_carry;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);

endmodule
